// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver: receive
//               FSM state encoding, default frame/FIFO sizing and an even
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int CPP_DEFAULT        = 16;
  localparam int DATA_BITS_DEFAULT  = 8;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  // Even parity bit for up to 32 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on rd_data whenever the FIFO is not empty (zero
//               otherwise). empty/full/count are registered. A write into a
//               full FIFO is accepted when a read happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             empty_q;
  logic             full_q;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // A pop needs data; a push needs room, or a simultaneous pop freeing a slot.
  assign w_rd_ok = rd_en & ~empty_q;
  assign w_wr_ok = wr_en & (~full_q | w_rd_ok);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because rd_data is gated by empty.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (w_wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
    end
  end

  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling UART receiver with integrated FWFT byte FIFO.
//               2-flop synchroniser, falling-edge start detection, mid-bit
//               sampling, stop-bit check, sticky frame/overrun flags.
//               Optional even parity when UART_RX_PARITY_EN is defined
//               (adds PARITY state and the sticky parity_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CPP_DEFAULT,
  parameter int DATA_BITS        = DATA_BITS_DEFAULT,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_busy,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int TW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(DATA_BITS+1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_busy_q;
  logic                 sync1_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic                 w_fell;
  logic                 w_stop_sample;
  logic                 w_frame_good;
  logic                 w_frame_set;
  logic                 w_overrun_set;

`ifdef UART_RX_PARITY_EN
  logic                 par_ok_q;
  logic                 parity_err_q;
  logic                 w_par_sample;
  logic                 w_par_exp;
  logic                 w_parity_set;
`endif

  // Bring the asynchronous line into the clock domain and keep one history bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Start detection is edge-based so a line stuck low cannot retrigger.
  assign w_fell = rx_prev_q & ~rx_s_q;

  assign w_stop_sample = (state_q == STOP) && (tick_q == FULL_M1);
  assign w_frame_set   = w_stop_sample && !rx_s_q;

`ifdef UART_RX_PARITY_EN
  assign w_par_sample = (state_q == PARITY) && (tick_q == FULL_M1);
  assign w_par_exp    = even_parity(32'(shift_q));
  assign w_parity_set = w_par_sample && (rx_s_q != w_par_exp);
  assign w_frame_good = w_stop_sample && rx_s_q && par_ok_q;
`else
  assign w_frame_good = w_stop_sample && rx_s_q;
`endif

  // A good byte is lost only if the FIFO is full and nothing is read this edge.
  assign w_overrun_set = w_frame_good && full && !rd_en;

  // Receive FSM: start validation, mid-bit data sampling and stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (w_fell) begin
            state_q   <= START;
            tick_q    <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (tick_q == HALF_M1) begin
            if (rx_s_q) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q   <= DATA;
              tick_q    <= '0;
              bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              par_ok_q  <= 1'b1;
`endif
            end
          end else begin
            tick_q <= tick_q + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_q == FULL_M1) begin
            tick_q  <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_ONE;
            end
          end else begin
            tick_q <= tick_q + TICK_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_q == FULL_M1) begin
            tick_q   <= '0;
            par_ok_q <= (rx_s_q == w_par_exp);
            state_q  <= STOP;
          end else begin
            tick_q <= tick_q + TICK_ONE;
          end
        end
`endif
        STOP: begin
          if (tick_q == FULL_M1) begin
            tick_q    <= '0;
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end else begin
            tick_q <= tick_q + TICK_ONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error on the same edge as err_clr keeps the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (w_frame_set)        frame_err_q <= 1'b1;
      else if (err_clr)       frame_err_q <= 1'b0;
      if (w_overrun_set)      overrun_q   <= 1'b1;
      else if (err_clr)       overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w_parity_set)       parity_err_q <= 1'b1;
      else if (err_clr)       parity_err_q <= 1'b0;
`endif
    end
  end

  uart_rx_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_frame_good),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (CPP=16, 8 data bits,
//               8-deep FIFO). Directed scenarios plus randomised frames
//               checked against a queue-based model of the receiver.
//               Honours UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPP   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pin_cyc  = 0;
  int empty_fall_cyc = -1;
  int busy_rise_cyc  = -1;
  int busy_fall_cyc  = -1;
  logic empty_prev = 1'b1;
  logic busy_prev  = 1'b0;

  logic [7:0] exp_q[$];
  logic       fe;
  logic       ov;

  uart_rx_fifo #(
    .CLOCKS_PER_PULSE (CPP),
    .DATA_BITS        (8),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timestamp output transitions (edge count) for latency checks.
  always @(negedge clk) begin
    empty_prev <= empty;
    busy_prev  <= rx_busy;
    if (empty_prev === 1'b1 && empty === 1'b0) empty_fall_cyc <= cyc;
    if (busy_prev === 1'b0 && rx_busy === 1'b1) busy_rise_cyc <= cyc;
    if (busy_prev === 1'b1 && rx_busy === 1'b0) busy_fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full frame on the pin: start, 8 data bits LSB first, [parity], stop, idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    pin_cyc = cyc;
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPP);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(CPP);
`endif
    rx = stop_bit;
    tick(CPP);
    rx = 1'b1;
    tick(CPP);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_empty"}, empty, (exp_q.size() == 0));
    if (exp_q.size() != 0) check({tag, "_data"}, data_out, exp_q[0]);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check({tag, "_count"}, count, exp_q.size());
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    fe = 1'b0; ov = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state
    check("rst_data_out", data_out, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);

    // Single byte: latency of busy and empty relative to the pin edge
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    check("a5_busy_rise", busy_rise_cyc - pin_cyc, 3);
    check("a5_empty_fall", empty_fall_cyc - pin_cyc, 155);
    check("a5_count", count, 1);
    pop_check("a5_pop");
    check("a5_data_zero", data_out, 0);

    // Short glitch is rejected at the start sample
    pin_cyc = cyc;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    check("gl_busy_fall", busy_fall_cyc - pin_cyc, 11);
    check("gl_empty", empty, 1);
    check("gl_frame_err", frame_err, 0);
    check("gl_overrun", overrun, 0);

    // Stop bit low -> frame error, byte discarded
    send_frame(8'h3C, 1'b0);
    check("fe_flag", frame_err, 1);
    check("fe_empty", empty, 1);
    clear_errors();
    check("fe_cleared", frame_err, 0);
    send_frame(8'h01, 1'b1);
    exp_q.push_back(8'h01);
    pop_check("fe_next");

    // Clear on the exact edge of a new frame error: the error must win
    fork
      send_frame(8'h3C, 1'b0);
      begin
        tick(154);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
      end
    join
    check("setwins_frame_err", frame_err, 1);
    clear_errors();

    // Nine bytes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      else ov = 1'b1;
    end
    check("ov_full", full, 1);
    check("ov_count", count, 8);
    check("ov_flag", overrun, ov);
    while (exp_q.size() != 0) pop_check("ov_drain");
    check("ov_full_after", full, 0);
    clear_errors();
    ov = 1'b0;
    check("ov_cleared", overrun, 0);

    // Read on the same edge as a push into a full FIFO
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
    end
    fork
      send_frame(8'h18, 1'b1);
      begin
        tick(154);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h18);
    check("rw_count", count, 8);
    check("rw_full", full, 1);
    check("rw_overrun", overrun, 0);
    while (exp_q.size() != 0) pop_check("rw_drain");

    // Reset in the middle of data bit 4 aborts the frame and flushes the FIFO
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    send_frame(8'h3C, 1'b0);
    check("mr_pre_count", count, 1);
    check("mr_pre_fe", frame_err, 1);
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 4; i++) begin
      rx = 1'($urandom_range(0, 1));
      tick(CPP);
    end
    rx = 1'b1;
    tick(5);
    check("mr_busy_mid", rx_busy, 1);
    rst = 1'b1;
    tick(1);
    check("mr_data_out", data_out, 0);
    check("mr_empty", empty, 1);
    check("mr_full", full, 0);
    check("mr_count", count, 0);
    check("mr_busy", rx_busy, 0);
    check("mr_frame_err", frame_err, 0);
    check("mr_overrun", overrun, 0);
    rst = 1'b0;
    exp_q.delete();
    tick(CPP);
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    pop_check("mr_7e");

`ifdef UART_RX_PARITY_EN
    // Wrong even-parity bit drops the byte and raises parity_err
    check("par_clean", parity_err, 0);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    check("par_flag", parity_err, 1);
    check("par_empty", empty, 1);
    clear_errors();
    check("par_cleared", parity_err, 0);
`endif

    // Randomised frames against the queue model
    fe = 1'b0; ov = 1'b0;
    for (int it = 0; it < 12; it++) begin
      logic [7:0] b;
      logic       sb;
      int         npop;
      b    = 8'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      send_frame(b, sb);
      if (!sb) fe = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ov = 1'b1;
      check("rnd_frame_err", frame_err, fe);
      check("rnd_overrun", overrun, ov);
      check("rnd_count", count, exp_q.size());
      check("rnd_full", full, (exp_q.size() == DEPTH));
      npop = $urandom_range(0, 1);
      for (int k = 0; k < npop; k++) begin
        if (exp_q.size() != 0) pop_check("rnd_pop");
      end
    end
    while (exp_q.size() != 0) pop_check("rnd_drain");
    check("end_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
